// File: rtl/prim_deglitch_multi_if.sv
`default_nettype none
// ============================================================================
// Module   : prim_deglitch_multi_if
// Purpose  : Control, data and pulse bundle of the multi-channel deglitcher.
// Revision : 1.0 - initial release
// ============================================================================
interface prim_deglitch_multi_if #(
    parameter int unsigned Width    = 1,
    parameter int unsigned CntWidth = 4
);
    logic                en_i;
    logic                mode_i;
    logic [CntWidth-1:0] thresh_i;
    logic [Width-1:0]    d_i;
    logic [Width-1:0]    q_o;
    logic [Width-1:0]    rise_o;
    logic [Width-1:0]    fall_o;

    modport master (
        output en_i, mode_i, thresh_i, d_i,
        input  q_o, rise_o, fall_o
    );

    modport slave (
        input  en_i, mode_i, thresh_i, d_i,
        output q_o, rise_o, fall_o
    );
endinterface
`default_nettype wire

// File: rtl/prim_deglitch_multi.sv
`default_nettype none
// ============================================================================
// Module   : prim_deglitch_multi
// Purpose  : Per-channel input deglitcher, integrating or consecutive mode,
//            with registered level and single-cycle rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
module prim_deglitch_multi #(
    parameter int unsigned Width      = 1,
    parameter int unsigned CntWidth   = 4,
    parameter bit          AsyncOn    = 1'b0,
    parameter bit          ResetValue = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    prim_deglitch_multi_if.slave   bus
);
    localparam logic [CntWidth:0]   c_one_ext = {{CntWidth{1'b0}}, 1'b1};
    localparam logic [CntWidth-1:0] c_one_cnt = {{(CntWidth-1){1'b0}}, 1'b1};

    logic [Width-1:0] w_d_s;
    logic [Width-1:0] w_q;
    logic [Width-1:0] w_rise;
    logic [Width-1:0] w_fall;
    logic [CntWidth:0] w_thr;

    // A zero threshold behaves as one; extra MSB keeps cnt+1 from wrapping.
    assign w_thr = (bus.thresh_i == '0) ? c_one_ext : {1'b0, bus.thresh_i};

    generate
        if (AsyncOn) begin : g_sync
            logic [Width-1:0] r_sync1;
            logic [Width-1:0] r_sync2;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_sync1 <= {Width{ResetValue}};
                    r_sync2 <= {Width{ResetValue}};
                end else begin
                    r_sync1 <= bus.d_i;
                    r_sync2 <= r_sync1;
                end
            end

            assign w_d_s = r_sync2;
        end else begin : g_nosync
            assign w_d_s = bus.d_i;
        end

        for (genvar i = 0; i < Width; i++) begin : g_ch
            logic [CntWidth-1:0] r_cnt;
            logic                r_q;
            logic                r_rise;
            logic                r_fall;
            logic                w_mis;
            logic [CntWidth:0]   w_inc;

            assign w_mis = w_d_s[i] ^ r_q;
            assign w_inc = {1'b0, r_cnt} + c_one_ext;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cnt  <= '0;
                    r_q    <= ResetValue;
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                end else begin
                    r_rise <= 1'b0;
                    r_fall <= 1'b0;
                    if (bus.en_i) begin
                        if (w_mis) begin
                            if (w_inc >= w_thr) begin
                                r_q    <= ~r_q;
                                r_cnt  <= '0;
                                r_rise <= ~r_q;
                                r_fall <= r_q;
                            end else begin
                                r_cnt <= w_inc[CntWidth-1:0];
                            end
                        end else if (!bus.mode_i) begin
                            if (r_cnt != '0) begin
                                r_cnt <= r_cnt - c_one_cnt;
                            end
                        end else begin
                            r_cnt <= '0;
                        end
                    end
                end
            end

            assign w_q[i]    = r_q;
            assign w_rise[i] = r_rise;
            assign w_fall[i] = r_fall;
        end
    endgenerate

    assign bus.q_o    = w_q;
    assign bus.rise_o = w_rise;
    assign bus.fall_o = w_fall;
endmodule
`default_nettype wire

// File: tb/tb_prim_deglitch_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_prim_deglitch_multi
// Purpose  : Scoreboard bench for a 1-channel direct and a 4-channel
//            synchronised deglitcher sharing clock, reset and controls.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prim_deglitch_multi;
    logic clk_i  = 1'b0;
    logic rst_ni = 1'b0;

    always #5 clk_i = ~clk_i;

    prim_deglitch_multi_if #(.Width(1), .CntWidth(4)) ifa ();
    prim_deglitch_multi_if #(.Width(4), .CntWidth(4)) ifb ();

    prim_deglitch_multi #(
        .Width(1), .CntWidth(4), .AsyncOn(1'b0), .ResetValue(1'b0)
    ) dut_a (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (ifa.slave)
    );

    prim_deglitch_multi #(
        .Width(4), .CntWidth(4), .AsyncOn(1'b1), .ResetValue(1'b0)
    ) dut_b (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .bus    (ifb.slave)
    );

    typedef struct packed {
        logic       aq, ar, af;
        logic [3:0] bq, br, bf;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference state, advanced once per clock edge.
    logic       ma_q;
    int         ma_cnt;
    logic [3:0] mb_q;
    int         mb_cnt [4];
    logic [3:0] ms1, ms2;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic chan(input logic en, input logic mode, input int thr_raw, input logic d,
                        inout logic q, inout int cnt, output logic r, output logic f);
        int thr;
        thr = (thr_raw == 0) ? 1 : thr_raw;
        r = 1'b0;
        f = 1'b0;
        if (en) begin
            if (d != q) begin
                if (cnt + 1 >= thr) begin
                    q   = ~q;
                    cnt = 0;
                    r   = q;
                    f   = ~q;
                end else begin
                    cnt = cnt + 1;
                end
            end else if (!mode) begin
                if (cnt > 0) cnt = cnt - 1;
            end else begin
                cnt = 0;
            end
        end
    endtask

    task automatic model_reset();
        ma_q   = 1'b0;
        ma_cnt = 0;
        mb_q   = 4'b0;
        for (int i = 0; i < 4; i++) mb_cnt[i] = 0;
        ms1 = 4'b0;
        ms2 = 4'b0;
        sb.delete();
    endtask

    task automatic cyc(input logic en, input logic mode, input int thr, input logic da, input logic [3:0] db);
        exp_t e;
        logic r, f, tq;
        int   tc;
        ifa.en_i = en; ifa.mode_i = mode; ifa.thresh_i = thr[3:0]; ifa.d_i = da;
        ifb.en_i = en; ifb.mode_i = mode; ifb.thresh_i = thr[3:0]; ifb.d_i = db;
        chan(en, mode, thr, da, ma_q, ma_cnt, r, f);
        e.aq = ma_q; e.ar = r; e.af = f;
        for (int i = 0; i < 4; i++) begin
            tq = mb_q[i];
            tc = mb_cnt[i];
            chan(en, mode, thr, ms2[i], tq, tc, r, f);
            mb_q[i] = tq; mb_cnt[i] = tc;
            e.bq[i] = tq; e.br[i] = r; e.bf[i] = f;
        end
        ms2 = ms1;
        ms1 = db;
        sb.push_back(e);
        @(posedge clk_i);
        #1;
        e = sb.pop_front();
        check("sb_a", {29'd0, ifa.q_o, ifa.rise_o, ifa.fall_o}, {29'd0, e.aq, e.ar, e.af});
        check("sb_b", {20'd0, ifb.q_o, ifb.rise_o, ifb.fall_o}, {20'd0, e.bq, e.br, e.bf});
    endtask

    task automatic check_idle(input string tag);
        check(tag, {20'd0, ifb.q_o, ifb.rise_o, ifb.fall_o}, 32'd0);
        check(tag, {29'd0, ifa.q_o, ifa.rise_o, ifa.fall_o}, 32'd0);
    endtask

    initial begin
        logic [3:0] rnd;
        ifa.en_i = 1'b1; ifa.mode_i = 1'b0; ifa.thresh_i = 4'd1; ifa.d_i = 1'b1;
        ifb.en_i = 1'b1; ifb.mode_i = 1'b0; ifb.thresh_i = 4'd1; ifb.d_i = 4'hF;
        model_reset();

        // Reset held with inputs high: outputs stay at reset level.
        repeat (3) begin
            @(posedge clk_i);
            #1;
            check_idle("reset_hold");
        end
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Clean step, threshold 4, integrating.
        for (int k = 1; k <= 5; k++) begin
            rnd = 4'($urandom);
            cyc(1'b1, 1'b0, 4, 1'b1, rnd);
            if (k == 3) check("step_q3", {31'd0, ifa.q_o}, 32'd0);
            if (k == 4) check("step_q4", {30'd0, ifa.q_o, ifa.rise_o}, 32'd3);
            if (k == 5) check("step_q5", {30'd0, ifa.q_o, ifa.rise_o}, 32'd2);
        end
        repeat (4) cyc(1'b1, 1'b0, 4, 1'b0, 4'($urandom));
        check("step_back", {31'd0, ifa.q_o}, 32'd0);

        // Integrating glitch 1,1,1,0,1 then 1,1.
        for (int k = 1; k <= 7; k++) begin
            cyc(1'b1, 1'b0, 4, (k == 4) ? 1'b0 : 1'b1, 4'($urandom));
            if (k == 5) check("integ_q5", {31'd0, ifa.q_o}, 32'd0);
            if (k == 7) check("integ_q7", {31'd0, ifa.q_o}, 32'd1);
        end
        repeat (4) cyc(1'b1, 1'b0, 4, 1'b0, 4'($urandom));

        // Consecutive glitch 1,1,1,0,1,1,1,1.
        for (int k = 1; k <= 8; k++) begin
            cyc(1'b1, 1'b1, 4, (k == 4) ? 1'b0 : 1'b1, 4'($urandom));
            if (k == 7) check("consec_q7", {31'd0, ifa.q_o}, 32'd0);
            if (k == 8) check("consec_q8", {30'd0, ifa.q_o, ifa.rise_o}, 32'd3);
        end
        repeat (4) cyc(1'b1, 1'b1, 4, 1'b0, 4'($urandom));

        // Enable gating, threshold 2.
        for (int k = 1; k <= 4; k++) begin
            cyc(k[0], 1'b0, 2, 1'b1, 4'($urandom));
            if (k == 2) check("gate_q2", {31'd0, ifa.q_o}, 32'd0);
            if (k == 3) check("gate_q3", {30'd0, ifa.q_o, ifa.rise_o}, 32'd3);
            if (k == 4) check("gate_q4", {30'd0, ifa.q_o, ifa.rise_o}, 32'd2);
        end

        // Threshold 0 is a one-cycle pass-through.
        cyc(1'b1, 1'b0, 0, 1'b0, 4'($urandom));
        check("thr0_fall", {30'd0, ifa.q_o, ifa.fall_o}, 32'd1);

        // Lowering the threshold below the running count.
        repeat (5) cyc(1'b1, 1'b0, 8, 1'b1, 4'($urandom));
        check("lower_hold", {31'd0, ifa.q_o}, 32'd0);
        cyc(1'b1, 1'b0, 2, 1'b1, 4'($urandom));
        check("lower_tog", {30'd0, ifa.q_o, ifa.rise_o}, 32'd3);

        // Synchronised channels: settle high, then ch0 and ch3 fall together.
        repeat (8) cyc(1'b1, 1'b0, 3, 1'b0, 4'hF);
        check("async_hi", {28'd0, ifb.q_o}, 32'hF);
        for (int k = 1; k <= 5; k++) begin
            cyc(1'b1, 1'b0, 3, 1'b0, 4'b0110);
            if (k == 4) check("async_fall4", {24'd0, ifb.q_o, ifb.fall_o}, 32'hF0);
            if (k == 5) check("async_fall5", {24'd0, ifb.q_o, ifb.fall_o}, 32'h69);
        end

        // Asynchronous reset in the middle of a count.
        repeat (4) cyc(1'b1, 1'b0, 3, 1'b1, 4'b1001);
        #2;
        rst_ni = 1'b0;
        #1;
        check_idle("arst");
        model_reset();
        @(negedge clk_i);
        rst_ni = 1'b1;
        cyc(1'b1, 1'b0, 3, 1'b0, 4'b0000);
        check_idle("arst_after");

        // Random traffic against the reference.
        for (int k = 0; k < 300; k++) begin
            cyc($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 5),
                1'($urandom), 4'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
